// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction sequencer for the 32-bit core
module control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       opcode,
    input  logic             I,
    input  logic             flag_e,
    input  logic             flag_gt,
    output logic             instr_req,
    input  logic             instr_valid,
    output logic             ir_we,
    output logic             imm_sel,
    output logic             alu_start,
    input  logic             alu_done,
    output logic             flags_we,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_MOD  = 5'b00100;
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_BGT  = 5'b10001;
    localparam logic [4:0] OP_B    = 5'b10010;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    typedef enum logic [3:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MULW,
        S_MEM,
        S_WB,
        S_BRANCH,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    // State register, latched opcode, sticky illegal flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RESET;
            op_q      <= 5'd0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and strobe decode; strobes depend on state and the latched opcode
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        instr_req = 1'b0;
        ir_we     = 1'b0;
        imm_sel   = 1'b0;
        alu_start = 1'b0;
        flags_we  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'd0;
        pc_we     = 1'b0;
        pc_sel    = 2'd0;
        unique case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                instr_req = 1'b1;
                if (instr_valid) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // The only place the live opcode is looked at
                op_d = opcode;
                if (opcode <= OP_ST) begin
                    state_d = S_EXEC;
                end else if (opcode <= OP_RET) begin
                    state_d = S_BRANCH;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = (opcode != OP_HLT);
                end
            end
            S_EXEC: begin
                imm_sel = I;
                if (op_q >= OP_MUL && op_q <= OP_MOD) begin
                    alu_start = 1'b1;
                    state_d   = S_MULW;
                end else if (op_q == OP_CMP) begin
                    flags_we = 1'b1;
                    state_d  = S_WB;
                end else if (op_q == OP_LD || op_q == OP_ST) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MULW: begin
                if (alu_done) begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_ST);
                if (dmem_ready) begin
                    if (op_q == OP_ST) begin
                        // Stores have no write-back, so they finish here
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = (op_q != OP_CMP) && (op_q != OP_NOP);
                wb_sel  = (op_q == OP_LD) ? 2'd1 : 2'd0;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                pc_we = 1'b1;
                case (op_q)
                    OP_B:    pc_sel = 2'd1;
                    OP_CALL: begin
                        pc_sel = 2'd1;
                        rf_we  = 1'b1;
                        wb_sel = 2'd2;
                    end
                    OP_BEQ:  pc_sel = flag_e  ? 2'd1 : 2'd0;
                    OP_BGT:  pc_sel = flag_gt ? 2'd1 : 2'd0;
                    OP_RET:  pc_sel = 2'd2;
                    default: pc_sel = 2'd0;
                endcase
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - directed self-checking bench for control_unit
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  opcode = 5'd0;
    logic        I = 1'b0;
    logic        flag_e = 1'b0;
    logic        flag_gt = 1'b0;
    logic        instr_valid = 1'b0;
    logic        alu_done = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        instr_req, ir_we, imm_sel, alu_start, flags_we;
    logic        dmem_req, dmem_we, rf_we, pc_we, halted, illegal;
    logic [1:0]  wb_sel, pc_sel;
    logic [31:0] retired;
    logic [14:0] outs;

    int checks = 0;
    int failures = 0;

    control_unit #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .I(I),
        .flag_e(flag_e), .flag_gt(flag_gt),
        .instr_req(instr_req), .instr_valid(instr_valid), .ir_we(ir_we),
        .imm_sel(imm_sel), .alu_start(alu_start), .alu_done(alu_done),
        .flags_we(flags_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ready(dmem_ready), .rf_we(rf_we), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    assign outs = {instr_req, ir_we, imm_sel, alu_start, flags_we, dmem_req,
                   dmem_we, rf_we, wb_sel, pc_we, pc_sel, halted, illegal};

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; instr_valid = 1'b1; opcode = 5'b00000; I = 1'b1;
        step; step; step;
        checks++;
        if (outs !== 15'd0 || retired !== 32'd0) begin
            failures++; $display("FAIL reset_outputs outs=%h retired=%0d expected 0/0", outs, retired);
        end
        rst_n = 1'b1;
        step;
        checks++;
        if (instr_req !== 1'b1 || ir_we !== 1'b1) begin
            failures++; $display("FAIL reset_fetch req=%b ir_we=%b expected 1/1", instr_req, ir_we);
        end
    endtask

    task automatic test_add;
        step;
        instr_valid = 1'b0;
        checks++;
        if (outs !== 15'd0) begin
            failures++; $display("FAIL add_decode outs=%h expected 0", outs);
        end
        step;
        checks++;
        if (imm_sel !== 1'b1 || rf_we !== 1'b0 || pc_we !== 1'b0) begin
            failures++; $display("FAIL add_exec imm=%b rf=%b pc=%b expected 1/0/0", imm_sel, rf_we, pc_we);
        end
        step;
        checks++;
        if (rf_we !== 1'b1 || pc_we !== 1'b1 || pc_sel !== 2'd0 || wb_sel !== 2'd0 || imm_sel !== 1'b0) begin
            failures++; $display("FAIL add_wb rf=%b pc=%b pcs=%0d wbs=%0d imm=%b expected 1/1/0/0/0",
                                 rf_we, pc_we, pc_sel, wb_sel, imm_sel);
        end
        step;
        checks++;
        if (instr_req !== 1'b1 || retired !== 32'd1) begin
            failures++; $display("FAIL add_retire req=%b retired=%0d expected 1/1", instr_req, retired);
        end
    endtask

    task automatic test_ld_wait;
        int req_cycles = 0;
        opcode = 5'b01110; I = 1'b0; instr_valid = 1'b1;
        step; instr_valid = 1'b0;
        step;
        for (int i = 0; i < 4; i++) begin
            step;
            if (i == 3) dmem_ready = 1'b1;
            if (dmem_req === 1'b1 && dmem_we === 1'b0) req_cycles++;
        end
        step; dmem_ready = 1'b0;
        checks++;
        if (req_cycles != 4) begin
            failures++; $display("FAIL ld_req_held cycles=%0d expected 4", req_cycles);
        end
        checks++;
        if (wb_sel !== 2'd1 || rf_we !== 1'b1 || dmem_req !== 1'b0) begin
            failures++; $display("FAIL ld_wb wbs=%0d rf=%b req=%b expected 1/1/0", wb_sel, rf_we, dmem_req);
        end
        step;
        checks++;
        if (instr_req !== 1'b1 || retired !== 32'd2) begin
            failures++; $display("FAIL ld_latency req=%b retired=%0d expected 1/2", instr_req, retired);
        end
    endtask

    task automatic test_cmp_branch;
        opcode = 5'b00101; instr_valid = 1'b1;
        step; instr_valid = 1'b0;
        step;
        checks++;
        if (flags_we !== 1'b1 || rf_we !== 1'b0) begin
            failures++; $display("FAIL cmp_exec flags_we=%b rf=%b expected 1/0", flags_we, rf_we);
        end
        step;
        checks++;
        if (rf_we !== 1'b0 || pc_we !== 1'b1 || flags_we !== 1'b0) begin
            failures++; $display("FAIL cmp_wb rf=%b pc=%b flags=%b expected 0/1/0", rf_we, pc_we, flags_we);
        end
        step;
        opcode = 5'b10000; flag_e = 1'b1; instr_valid = 1'b1;
        step; instr_valid = 1'b0;
        step;
        checks++;
        if (pc_we !== 1'b1 || pc_sel !== 2'd1 || rf_we !== 1'b0) begin
            failures++; $display("FAIL beq_taken pc=%b pcs=%0d rf=%b expected 1/1/0", pc_we, pc_sel, rf_we);
        end
        step;
        opcode = 5'b10001; flag_gt = 1'b0; instr_valid = 1'b1;
        step; instr_valid = 1'b0;
        step;
        checks++;
        if (pc_we !== 1'b1 || pc_sel !== 2'd0) begin
            failures++; $display("FAIL bgt_not_taken pc=%b pcs=%0d expected 1/0", pc_we, pc_sel);
        end
        step;
        checks++;
        if (instr_req !== 1'b1 || retired !== 32'd5) begin
            failures++; $display("FAIL branch_retire req=%b retired=%0d expected 1/5", instr_req, retired);
        end
        flag_e = 1'b0;
    endtask

    task automatic test_div_call;
        int starts = 0;
        opcode = 5'b00011; instr_valid = 1'b1;
        step; instr_valid = 1'b0;
        if (alu_start === 1'b1) starts++;
        step;
        if (alu_start === 1'b1) starts++;
        for (int i = 0; i < 5; i++) begin
            step;
            if (i == 4) alu_done = 1'b1;
            if (alu_start === 1'b1) starts++;
            if (rf_we === 1'b1) starts += 100;
        end
        step; alu_done = 1'b0;
        checks++;
        if (starts != 1) begin
            failures++; $display("FAIL div_start_pulses got=%0d expected 1", starts);
        end
        checks++;
        if (rf_we !== 1'b1 || wb_sel !== 2'd0 || pc_we !== 1'b1) begin
            failures++; $display("FAIL div_wb rf=%b wbs=%0d pc=%b expected 1/0/1", rf_we, wb_sel, pc_we);
        end
        step;
        checks++;
        if (instr_req !== 1'b1 || retired !== 32'd6) begin
            failures++; $display("FAIL div_latency req=%b retired=%0d expected 1/6", instr_req, retired);
        end
        opcode = 5'b10011; instr_valid = 1'b1;
        step; instr_valid = 1'b0; alu_done = 1'b1;
        step; alu_done = 1'b0;
        checks++;
        if (pc_sel !== 2'd1 || rf_we !== 1'b1 || wb_sel !== 2'd2 || pc_we !== 1'b1) begin
            failures++; $display("FAIL call_branch pcs=%0d rf=%b wbs=%0d pc=%b expected 1/1/2/1",
                                 pc_sel, rf_we, wb_sel, pc_we);
        end
        step;
        checks++;
        if (instr_req !== 1'b1 || retired !== 32'd7) begin
            failures++; $display("FAIL call_retire req=%b retired=%0d expected 1/7", instr_req, retired);
        end
    endtask

    task automatic test_back_to_back;
        opcode = 5'b01111; I = 1'b1; instr_valid = 1'b1;
        step; instr_valid = 1'b0;
        step; opcode = 5'b11111;
        checks++;
        if (imm_sel !== 1'b1 || dmem_req !== 1'b0) begin
            failures++; $display("FAIL st_exec imm=%b req=%b expected 1/0", imm_sel, dmem_req);
        end
        step;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || pc_we !== 1'b0) begin
            failures++; $display("FAIL st_mem req=%b we=%b pc=%b expected 1/1/0", dmem_req, dmem_we, pc_we);
        end
        dmem_ready = 1'b1; #1;
        checks++;
        if (pc_we !== 1'b1 || pc_sel !== 2'd0 || rf_we !== 1'b0) begin
            failures++; $display("FAIL st_ready pc=%b pcs=%0d rf=%b expected 1/0/0", pc_we, pc_sel, rf_we);
        end
        step; dmem_ready = 1'b0;
        checks++;
        if (instr_req !== 1'b1 || retired !== 32'd8 || halted !== 1'b0) begin
            failures++; $display("FAIL st_retire req=%b retired=%0d halted=%b expected 1/8/0",
                                 instr_req, retired, halted);
        end
        I = 1'b0;
    endtask

    task automatic test_illegal_hlt;
        int reqs = 0;
        opcode = 5'b01110; instr_valid = 1'b1;
        step; instr_valid = 1'b0;
        step; step;
        rst_n = 1'b0; #1;
        checks++;
        if (outs !== 15'd0 || retired !== 32'd0) begin
            failures++; $display("FAIL reset_abort outs=%h retired=%0d expected 0/0", outs, retired);
        end
        step; step;
        opcode = 5'b10110; instr_valid = 1'b1; rst_n = 1'b1;
        step; step; step;
        checks++;
        if (halted !== 1'b1 || illegal !== 1'b1) begin
            failures++; $display("FAIL illegal_halt halted=%b illegal=%b expected 1/1", halted, illegal);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            if (instr_req !== 1'b0 || halted !== 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0 || retired !== 32'd0) begin
            failures++; $display("FAIL illegal_sticky bad=%0d retired=%0d expected 0/0", reqs, retired);
        end
        rst_n = 1'b0;
        step; step;
        opcode = 5'b11111; rst_n = 1'b1;
        step; step; step;
        checks++;
        if (halted !== 1'b1 || illegal !== 1'b0 || retired !== 32'd0 || instr_req !== 1'b0) begin
            failures++; $display("FAIL hlt_halt halted=%b illegal=%b retired=%0d req=%b expected 1/0/0/0",
                                 halted, illegal, retired, instr_req);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_ld_wait;
        test_cmp_branch;
        test_div_call;
        test_back_to_back;
        test_illegal_hlt;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
